// File: rtl/ibex_icache_ecc_checker_pkg.sv
// Shared constants and types for the icache ECC protocol checker:
// error-bit positions, error-vector width and the counter type.
package ibex_icache_ecc_checker_pkg;

    localparam int unsigned ErrWidth       = 6;
    localparam int unsigned ErrMaskNoRead  = 0;
    localparam int unsigned ErrMaskRange   = 1;
    localparam int unsigned ErrMaskPopcnt  = 2;
    localparam int unsigned ErrWidthRange  = 3;
    localparam int unsigned ErrWmaskRange  = 4;
    localparam int unsigned ErrMaskHold    = 5;

    typedef logic [31:0] count_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic count_t sat_inc(input count_t value);
        return (&value) ? value : value + count_t'(1);
    endfunction

endpackage

// File: rtl/ibex_icache_ecc_popcount_le2.sv
// Reports whether a vector has at most two bits set.
module ibex_icache_ecc_popcount_le2 #(
    parameter int unsigned Width = 128
) (
    input  logic [Width-1:0] vec,
    output logic             le2
);

    logic seen_one;
    logic seen_two;
    logic seen_three;

    // Saturating "at least N ones" chain; order of updates matters.
    always_comb begin
        seen_one   = 1'b0;
        seen_two   = 1'b0;
        seen_three = 1'b0;
        for (int i = 0; i < Width; i++) begin
            seen_three = seen_three | (seen_two & vec[i]);
            seen_two   = seen_two   | (seen_one & vec[i]);
            seen_one   = seen_one   | vec[i];
        end
        le2 = ~seen_three;
    end

endmodule

// File: rtl/ibex_icache_ecc_protocol_checker.sv
// Protocol checker for icache RAM ECC corruption injection; sticky violation flags and read counters.
// Define ICACHE_ECC_CHECKER_SVA_EN to add concurrent assertions for each check plus an X-check.
module ibex_icache_ecc_protocol_checker
    import ibex_icache_ecc_checker_pkg::*;
#(
    parameter int unsigned MaxWidth = 128
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                write_i,
    input  logic [31:0]         width,
    input  logic [31:0]         addr,
    input  logic [MaxWidth-1:0] wdata,
    input  logic [MaxWidth-1:0] wmask,
    input  logic [MaxWidth-1:0] rdata,
    input  logic [MaxWidth-1:0] bad_bit_mask,
    output logic [ErrWidth-1:0] err_o,
    output logic                err_any_o,
    output logic [31:0]         read_count_o,
    output logic [31:0]         corrupt_count_o,
    output logic [31:0]         last_addr_o
);

    logic                read_start;
    logic                write_req;
    logic                width_ok;
    logic                mask_nonzero;
    logic                mask_le2;
    logic [MaxWidth-1:0] above_width;
    logic [ErrWidth-1:0] err_d;
    logic [ErrWidth-1:0] err_q;
    logic [MaxWidth-1:0] prev_mask_q;
    count_t              read_count_q;
    count_t              corrupt_count_q;
    logic [31:0]         last_addr_q;

    // Data buses are carried for completeness only; the checks never look at them.
    logic unused_data;
    assign unused_data = ^{wdata, rdata};

    assign read_start   = req_i & ~write_i;
    assign write_req    = req_i & write_i;
    assign width_ok     = (width != 32'd0) && (width <= 32'(MaxWidth));
    assign mask_nonzero = |bad_bit_mask;

    always_comb begin
        above_width = '0;
        for (int i = 0; i < MaxWidth; i++) begin
            above_width[i] = (32'(i) >= width);
        end
    end

    ibex_icache_ecc_popcount_le2 #(
        .Width (MaxWidth)
    ) u_popcount (
        .vec (bad_bit_mask),
        .le2 (mask_le2)
    );

    // Bit-range checks are only meaningful when the width itself is legal.
    always_comb begin
        err_d                = '0;
        err_d[ErrMaskNoRead] = mask_nonzero & ~read_start;
        err_d[ErrMaskRange]  = width_ok & |(bad_bit_mask & above_width);
        err_d[ErrMaskPopcnt] = ~mask_le2;
        err_d[ErrWidthRange] = ~width_ok;
        err_d[ErrWmaskRange] = width_ok & write_req & |(wmask & above_width);
        err_d[ErrMaskHold]   = mask_nonzero & (bad_bit_mask == prev_mask_q) & ~read_start;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q           <= '0;
            prev_mask_q     <= '0;
            read_count_q    <= '0;
            corrupt_count_q <= '0;
            last_addr_q     <= '0;
        end else begin
            err_q       <= err_q | err_d;
            prev_mask_q <= bad_bit_mask;
            if (read_start) begin
                read_count_q <= sat_inc(read_count_q);
                if (mask_nonzero) begin
                    corrupt_count_q <= sat_inc(corrupt_count_q);
                end
                last_addr_q <= addr;
            end
        end
    end

    assign err_o           = err_q;
    assign err_any_o       = |err_q;
    assign read_count_o    = read_count_q;
    assign corrupt_count_o = corrupt_count_q;
    assign last_addr_o     = last_addr_q;

`ifdef ICACHE_ECC_CHECKER_SVA_EN
    for (genvar g = 0; g < ErrWidth; g++) begin : g_check_sva
        a_check : assert property (@(posedge clk_i) disable iff (rst_i) !err_d[g]);
    end

    a_no_x_on_req : assert property (@(posedge clk_i) disable iff (rst_i)
        req_i |-> !$isunknown({write_i, addr, width}));
`else
`endif

endmodule

// File: tb/tb_ibex_icache_ecc_protocol_checker.sv
// Scoreboard testbench for ibex_icache_ecc_protocol_checker: a behavioural model pushes
// expected state each cycle, popped and compared one step after the clock edge.
module tb_ibex_icache_ecc_protocol_checker;

    localparam int unsigned MaxWidth = 128;

    typedef struct {
        logic [5:0]  err;
        logic        err_any;
        logic [31:0] rc;
        logic [31:0] cc;
        logic [31:0] last;
    } expect_t;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                req_i;
    logic                write_i;
    logic [31:0]         width;
    logic [31:0]         addr;
    logic [MaxWidth-1:0] wdata;
    logic [MaxWidth-1:0] wmask;
    logic [MaxWidth-1:0] rdata;
    logic [MaxWidth-1:0] bad_bit_mask;
    logic [5:0]          err_o;
    logic                err_any_o;
    logic [31:0]         read_count_o;
    logic [31:0]         corrupt_count_o;
    logic [31:0]         last_addr_o;

    int checks = 0;
    int errors = 0;

    expect_t scoreboard[$];

    logic [5:0]          m_err;
    logic [31:0]         m_rc;
    logic [31:0]         m_cc;
    logic [31:0]         m_last;
    logic [MaxWidth-1:0] m_prev;

    ibex_icache_ecc_protocol_checker #(
        .MaxWidth (MaxWidth)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_i           (req_i),
        .write_i         (write_i),
        .width           (width),
        .addr            (addr),
        .wdata           (wdata),
        .wmask           (wmask),
        .rdata           (rdata),
        .bad_bit_mask    (bad_bit_mask),
        .err_o           (err_o),
        .err_any_o       (err_any_o),
        .read_count_o    (read_count_o),
        .corrupt_count_o (corrupt_count_o),
        .last_addr_o     (last_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Independent model of the checker: state after the coming rising edge.
    task automatic modelStep(input logic rst, input logic req, input logic wr, input logic [31:0] w,
                             input logic [31:0] a, input logic [127:0] wm, input logic [127:0] m);
        logic rs;
        logic wok;
        if (rst) begin
            m_err = '0; m_rc = '0; m_cc = '0; m_last = '0; m_prev = '0;
        end else begin
            rs  = req && !wr;
            wok = (w >= 1) && (w <= MaxWidth);
            if (m != 0 && !rs)                          m_err[0] = 1'b1;
            if (wok && ((m >> w) != 0))                 m_err[1] = 1'b1;
            if ($countones(m) > 2)                      m_err[2] = 1'b1;
            if (!wok)                                   m_err[3] = 1'b1;
            if (wok && req && wr && ((wm >> w) != 0))   m_err[4] = 1'b1;
            if (m != 0 && m == m_prev && !rs)           m_err[5] = 1'b1;
            m_prev = m;
            if (rs) begin
                if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
                if (m != 0 && m_cc != 32'hFFFF_FFFF) m_cc = m_cc + 1;
                m_last = a;
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic req, input logic wr, input logic [31:0] w,
                                 input logic [31:0] a, input logic [127:0] wm, input logic [127:0] m);
        expect_t e;
        expect_t got;
        @(negedge clk_i);
        rst_i = rst; req_i = req; write_i = wr; width = w; addr = a; wmask = wm; bad_bit_mask = m;
        wdata = {4{$urandom}};
        rdata = {4{$urandom}};
        modelStep(rst, req, wr, w, a, wm, m);
        e.err = m_err; e.err_any = |m_err; e.rc = m_rc; e.cc = m_cc; e.last = m_last;
        scoreboard.push_back(e);
        @(posedge clk_i);
        #1;
        got = scoreboard.pop_front();
        checkOutput("err_o",           128'(err_o),           128'(got.err));
        checkOutput("err_any_o",       128'(err_any_o),       128'(got.err_any));
        checkOutput("read_count_o",    128'(read_count_o),    128'(got.rc));
        checkOutput("corrupt_count_o", 128'(corrupt_count_o), 128'(got.cc));
        checkOutput("last_addr_o",     128'(last_addr_o),     128'(got.last));
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd64, 32'd0, '0, '0);
    endtask

    initial begin
        logic [127:0] one = 128'd1;
        logic [127:0] m;
        logic [31:0]  w;
        rst_i = 1'b1; req_i = 1'b0; write_i = 1'b0; width = 32'd64; addr = '0;
        wdata = '0; wmask = '0; rdata = '0; bad_bit_mask = '0;
        m_err = '0; m_rc = '0; m_cc = '0; m_last = '0; m_prev = '0;

        doReset();
        checkOutput("reset_err_zero", 128'(err_o), 128'd0);

        // Legal single-cycle corruption on a read
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd64, 32'h100, '0, one << 5);
        checkOutput("legal_read_cc", 128'(corrupt_count_o), 128'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd64, 32'h0, '0, '0);

        // Out-of-width corruption bit
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd64, 32'h104, '0, one << 70);
        checkOutput("mask_range_bit", 128'(err_o[1]), 128'd1);
        doReset();

        // Corruption without a read, then three-bit corruption on a read
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd64, 32'h0, '0, 128'd3);
        checkOutput("mask_no_read_bit", 128'(err_o[0]), 128'd1);
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd64, 32'h8, '0, 128'h7);
        checkOutput("mask_popcount_bit", 128'(err_o[2]), 128'd1);
        doReset();

        // Write mask beyond width, illegal widths
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd32, 32'h40, 128'h1_0000_0000, '0);
        checkOutput("wmask_range_bit", 128'(err_o[4]), 128'd1);
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'h0, '0, '0);
        checkOutput("width_zero_bit", 128'(err_o), 128'h8);
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd200, 32'h0, '1, '0);
        checkOutput("width_big_only", 128'(err_o), 128'h8);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd128, 32'h0, '1, '0);
        doReset();

        // Back-to-back reads
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd64, 32'h10, '0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd64, 32'h20, '0, '0);
        checkOutput("b2b_last_addr", 128'(last_addr_o), 128'h20);
        checkOutput("b2b_read_count", 128'(read_count_o), 128'd2);

        // Held mask: two reads are fine, idle repeat trips hold
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd64, 32'h30, '0, 128'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd64, 32'h34, '0, 128'd1);
        checkOutput("hold_reads_ok", 128'(err_o), 128'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd64, 32'h0, '0, 128'd1);
        checkOutput("mask_hold_bit", 128'(err_o), 128'h21);

        // Reset wins over a simultaneous violation and read
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 32'h50, '0, 128'hF);
        checkOutput("reset_prio_err", 128'(err_o), 128'd0);
        checkOutput("reset_prio_rc", 128'(read_count_o), 128'd0);

        // Randomised mix
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 6))
                0: m = '0;
                1: m = one << 5;
                2: m = one << 70;
                3: m = 128'd3;
                4: m = 128'h7;
                5: m = one << 127;
                default: m = '0;
            endcase
            case ($urandom_range(0, 5))
                0: w = 32'd0;
                1: w = 32'd8;
                2: w = 32'd32;
                3: w = 32'd128;
                4: w = 32'd200;
                default: w = 32'd64;
            endcase
            applyStimulus($urandom_range(0, 15) == 0, 1'($urandom), 1'($urandom), w,
                          $urandom, one << $urandom_range(0, 127), m);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
